// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and width defaults for the instruction fetch unit.
// Holds the fetch FSM state encoding and the layout of one buffered entry.
package fetch_pkg;

  localparam int ADD_W  = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  // One buffered instruction; the fifo stores it as {pc, data}.
  typedef struct packed {
    logic [ADD_W-1:0]  pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO, async reset, sync flush, no bypass.
// Ports: push/wdata in, pop/rdata out, flush clears, full/empty/count status.
module fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

endmodule

// File: rtl/i_fetch_unit.sv
// i_fetch_unit: sequential fetch requester for the i_cache CPU port.
// Ports: enable/redirect control, cpu_* cache port (read only),
// inst_* valid/ready output to decode, hit/miss statistics.
module i_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   ADD_WIDTH  = ADD_W,
  parameter int                   DATA_WIDTH = DATA_W,
  parameter logic [ADD_WIDTH-1:0] RESET_PC   = '0,
  parameter int                   HIT_WAIT   = 1,
  parameter int                   FIFO_DEPTH = 2,
  parameter int                   CNT_WIDTH  = CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADD_WIDTH-1:0]  redirect_pc,
  output logic [ADD_WIDTH-1:0]  cpu_add,
  output logic                  cpu_ren,
  output logic                  cpu_wen,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  hit_miss,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADD_WIDTH-1:0]  inst_pc,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(HIT_WAIT + 2);
  localparam int EW = ADD_WIDTH + DATA_WIDTH;

  // wait_cnt == HW marks the first qualified sample; HW1 means counted.
  localparam logic [WW-1:0] HW  = WW'(HIT_WAIT);
  localparam logic [WW-1:0] HW1 = WW'(HIT_WAIT + 1);

  fetch_state_t         state;
  fetch_state_t         state_nx;
  logic [ADD_WIDTH-1:0] pc;
  logic [ADD_WIDTH-1:0] pend_pc;
  logic [ADD_WIDTH-1:0] next_pc;
  logic                 pend_valid;
  logic [WW-1:0]        wait_cnt;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        fifo_rdata;
  logic                 pop;
  logic                 push;
  logic                 qual;
  logic                 first;
  logic                 done;
  logic                 drop;
  logic                 room_idle;
  logic                 room_done;
  int                   occ_done;

  assign cpu_wen     = 1'b0;
  assign cpu_data_in = '0;

  // pc only moves in IDLE or at completion, so the address is stable
  // for the whole life of a request.
  assign cpu_add = pc;
  assign cpu_ren = (state == REQ);

  assign pop   = inst_valid & inst_ready;
  assign qual  = (state == REQ) && (wait_cnt >= HW);
  assign first = (state == REQ) && (wait_cnt == HW);
  assign done  = qual & hit_miss;
  assign drop  = pend_valid | redirect_valid;
  assign push  = done & ~drop;

  // A redirect flushes the buffer, so room is guaranteed that cycle.
  assign room_idle = redirect_valid | ~fifo_full | pop;

  always_comb begin
    occ_done  = int'(fifo_count) - int'(pop) + int'(push);
    room_done = redirect_valid || (occ_done < FIFO_DEPTH);
  end

  always_comb begin
    next_pc = pc + ADD_WIDTH'(1);
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable && room_idle) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (done && !(enable && room_done)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      wait_cnt   <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end
    end else if (done) begin
      pc         <= next_pc;
      pend_valid <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      // Mid-request redirects are parked; the last one wins.
      if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
      if (wait_cnt != HW1) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (first) begin
      if (hit_miss) begin
        if (hit_count != '1) begin
          hit_count <= hit_count + CNT_WIDTH'(1);
        end
      end else begin
        if (miss_count != '1) begin
          miss_count <= miss_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({pc, cpu_data_out}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid         = ~fifo_empty;
  assign {inst_pc, inst_data} = fifo_rdata;

endmodule
